vga_frame_receiver: RTL

Receive side of the 1600x1200 VGA link produced by the display driver. Consumes HSYNC/VSYNC/RED/GREEN/BLUE on the 162 MHz pixel clock and checks line and frame timing against VESA 1600x1200@60. Once locked, it reconstructs each active pixel's row/column and emits it with its 12-bit colour. It serves as the in-system loopback checker and bench monitor for the driver and the sprite path.

---
 rtl/vga_frame_receiver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_frame_receiver.sv
// VGA receive-side timing checker: locks to HSYNC/VSYNC and emits active pixels with row/col/colour.
// Latency 2 cycles input-to-pix_*/err_pulse; no backpressure (streaming monitor, never stalls).
module vga_frame_receiver #(
   parameter int   H_ACTIVE = 1600,
   parameter int   H_FP     = 64,
   parameter int   H_SYNC   = 192,
   parameter int   H_BP     = 304,
   parameter int   V_ACTIVE = 1200,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 3,
   parameter int   V_BP     = 46,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic        clock_162,
   input  logic        rst,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic [3:0]  RED,
   input  logic [3:0]  GREEN,
   input  logic [3:0]  BLUE,
   output logic        pix_valid,
   output logic [10:0] pix_row,
   output logic [11:0] pix_col,
   output logic [11:0] pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic        err_pulse,
   output logic [7:0]  err_count
);

   localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_STOP  = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_STOP  = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

   state_t      state, state_nx;
   logic        hs_q, vs_q, hs_prev, vs_prev;
   logic [11:0] rgb_q;
   logic        hs_edge, vs_edge;
   logic [11:0] hcnt, hcnt_nx;
   logic [10:0] vcnt, vcnt_nx;
   logic        vs_pend, vs_pend_nx, h_seen, v_seen;
   logic        vload, line_bad, frame_bad, viol, in_window, valid_nx, err_nx;

   always_ff @(posedge clock_162) begin
      if (rst) begin
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         hs_prev <= ~SYNC_POL;
         vs_prev <= ~SYNC_POL;
         rgb_q   <= '0;
      end else begin
         hs_q    <= HSYNC;
         vs_q    <= VSYNC;
         hs_prev <= hs_q;
         vs_prev <= vs_q;
         rgb_q   <= {RED, GREEN, BLUE};
      end
   end

   assign hs_edge = (hs_q == SYNC_POL) && (hs_prev != SYNC_POL);
   assign vs_edge = (vs_q == SYNC_POL) && (vs_prev != SYNC_POL);

   // *_nx counts describe the pixel currently in the input stage.
   always_comb begin
      hcnt_nx = hs_edge ? 12'd0 : ((hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1);
      vload   = hs_edge && (vs_edge || vs_pend);
      vcnt_nx = vcnt;
      if (vload)
         vcnt_nx = 11'd0;
      else if (hs_edge && (vcnt != 11'h7FF))
         vcnt_nx = vcnt + 11'd1;
      vs_pend_nx = vs_pend;
      if (vload)
         vs_pend_nx = 1'b0;
      else if (vs_edge && !hs_edge)
         vs_pend_nx = 1'b1;
      line_bad  = h_seen && (hs_edge ? (hcnt != H_LAST) : (hcnt == 12'hFFE));
      frame_bad = v_seen && (vload ? (vcnt != V_LAST) : (hs_edge && (vcnt == 11'h7FE)));
      viol      = line_bad || frame_bad;
      in_window = (hcnt_nx >= H_START) && (hcnt_nx <= H_STOP) &&
                  (vcnt_nx >= V_START) && (vcnt_nx <= V_STOP);
      valid_nx  = (state == ST_LOCKED) && in_window;
   end

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      case (state)
         ST_SEARCH: if (vload) state_nx = ST_VERIFY;
         ST_VERIFY: begin
            if (viol)
               state_nx = ST_SEARCH;
            else if (vload)
               state_nx = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (viol) begin
               state_nx = ST_SEARCH;
               err_nx   = 1'b1;
            end
         end
         default: state_nx = ST_SEARCH;
      endcase
   end

   always_ff @(posedge clock_162) begin
      if (rst) begin
         state       <= ST_SEARCH;
         hcnt        <= '0;
         vcnt        <= '0;
         vs_pend     <= 1'b0;
         h_seen      <= 1'b0;
         v_seen      <= 1'b0;
         pix_valid   <= 1'b0;
         pix_row     <= '0;
         pix_col     <= '0;
         pix_rgb     <= '0;
         frame_start <= 1'b0;
         err_pulse   <= 1'b0;
         err_count   <= '0;
      end else begin
         state       <= state_nx;
         hcnt        <= hcnt_nx;
         vcnt        <= vcnt_nx;
         vs_pend     <= vs_pend_nx;
         h_seen      <= h_seen || hs_edge;
         v_seen      <= v_seen || vload;
         pix_valid   <= valid_nx;
         if (valid_nx) begin
            pix_row <= vcnt_nx - V_START;
            pix_col <= hcnt_nx - H_START;
            pix_rgb <= rgb_q;
         end
         frame_start <= valid_nx && (hcnt_nx == H_START) && (vcnt_nx == V_START);
         err_pulse   <= err_nx;
         if (err_nx && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end

   assign locked = (state == ST_LOCKED);

endmodule
